mac3_accumulator: RTL and testbench
===================================

MAC3_ACCUMULATOR -- requirements
Module: mac3_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 10: accumulator/result width; legal range ACC_W >= 6.
REQ-002 SHALL have parameter LEN, default 4: products per result; legal range LEN >= 1.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port clr, input, 1: synchronous abort/clear.
REQ-006 SHALL have port in_valid, input, 1: prod is valid.
REQ-007 SHALL have port in_ready, output, 1: block accepts prod.
REQ-008 SHALL have port prod, input, 6: unsigned 3x3 product, 0..49.
REQ-009 SHALL have port out_valid, output, 1: result available.
REQ-010 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-011 SHALL have port out_sum, output, ACC_W: accumulated result.
REQ-012 SHALL have port out_ovf, output, 1: overflow occurred in this result.

Function
REQ-013 SHALL implement states IDLE (cnt=0), ACCUM (0<cnt<LEN) and HOLD (result presented).
REQ-014 SHALL drive in_ready=1 in IDLE/ACCUM and in_ready=0 in HOLD.
REQ-015 SHALL define a beat as in_valid&in_ready at a clock edge; with in_valid=0, state/acc/cnt hold.
REQ-016 SHALL, on a beat, load acc with prod zero-extended to ACC_W when cnt=0, else acc+prod; cnt increments.
REQ-017 SHALL, on the LENth beat, enter HOLD with out_valid=1 on the next cycle; out_sum equals the sum including that beat (latency 1 cycle from the last beat); LEN=1 goes IDLE->HOLD on every beat.
REQ-018 SHALL hold out_sum and out_ovf stable while out_valid=1 and out_ready=0.
REQ-019 SHALL, on out_valid&out_ready, return to IDLE next cycle with out_valid=0, acc=0, cnt=0, out_ovf=0; in_ready=1 from that next cycle.
REQ-020 SHALL give clr priority over beats and handshakes: next cycle IDLE, acc=0, cnt=0, out_valid=0, out_ovf=0; a pending result in HOLD is discarded.
REQ-021 SHALL set out_ovf sticky for the current result when an add carries out of ACC_W bits.
REQ-022 SHALL drive out_sum=acc only while out_valid=1, else 0.

Reset
REQ-023 SHALL, while rst_n=0, force IDLE, acc=0, cnt=0, out_valid=0, out_sum=0, out_ovf=0, in_ready=0.
REQ-024 SHALL drive in_ready=1 from the first clock edge after rst_n deasserts; reset mid-accumulation discards partial sums.

Configuration
REQ-025 SHALL, with macro MAC3_ACC_SAT_EN defined, clamp acc to 2^ACC_W-1 on carry-out (and stay clamped) while setting out_ovf.
REQ-026 SHALL, without MAC3_ACC_SAT_EN, wrap acc modulo 2^ACC_W, out_ovf still set.

Structure
REQ-027 SHALL take PROD_W=6, PROD_MAX=49 and the IDLE/ACCUM/HOLD state enum from shared package mac3_pkg.
REQ-028 SHALL place the add/carry/saturate datapath in sub-module mac3_acc_add (ACC_W parameter, sat behaviour per macro).

Verification
REQ-029 SHALL cover: defaults, beats 42,49,1,0 back-to-back, out_ready=1 -> out_valid one cycle after 4th beat, out_sum=92, out_ovf=0.
REQ-030 SHALL cover: same stream, out_ready=0 for 5 cycles -> out_sum=92 stable, in_ready=0 throughout, in_valid ignored; release -> IDLE next cycle.
REQ-031 SHALL cover: ACC_W=7, beats 49,49,49,0 -> out_ovf=1, out_sum=19 without macro, 127 with MAC3_ACC_SAT_EN.
REQ-032 SHALL cover: beats 10,20 then clr coincident with beat 30 -> beat dropped, next 4 beats 1,2,3,4 give out_sum=10.
REQ-033 SHALL cover: LEN=1, beats 7,9 with out_ready=1 -> two results 7 and 9; rst_n pulsed low mid-stream of defaults -> all outputs 0 asynchronously, fresh sum after release.

Source files
------------

// File: rtl/mac3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac3_pkg
// Purpose  : Shared constants and state encoding for the 3x3-product
//            multiply-accumulate block (mac3_accumulator).
// Revision : 1.0 - initial release
// ============================================================================
package mac3_pkg;

  // Width and maximum value of an unsigned 3-bit x 3-bit product (7*7).
  localparam int PROD_W   = 6;
  localparam int PROD_MAX = 49;

  // IDLE: no product taken yet, ACCUM: partial sum in progress,
  // HOLD: finished result presented and waiting for the consumer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } mac3_state_t;

endpackage
`default_nettype wire

// File: rtl/mac3_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : mac3_accumulator_if
// Purpose  : Product-in / result-out handshake bundle for mac3_accumulator.
//            master = producer/consumer side, slave = accumulator side.
// Revision : 1.0 - initial release
// ============================================================================
interface mac3_accumulator_if #(
  parameter int ACC_W = 10
) ();
  import mac3_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;

  modport master (
    output in_valid, prod, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, prod, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

endinterface
`default_nettype wire

// File: rtl/mac3_acc_add.sv
`default_nettype none
// ============================================================================
// Module   : mac3_acc_add
// Purpose  : Accumulator adder. Either loads the product (first beat of a
//            result) or adds it to the running sum, reporting carry-out of
//            ACC_W bits.
//            Optional macro MAC3_ACC_SAT_EN: clamp to all-ones on carry-out
//            instead of wrapping modulo 2^ACC_W.
// Revision : 1.0 - initial release
// ============================================================================
module mac3_acc_add
  import mac3_pkg::*;
#(
  parameter int ACC_W = 10
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_prod,
  input  logic              i_load,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_carry
);

  localparam int c_EXT_W = ACC_W + 1 - PROD_W;

  logic [ACC_W:0] w_full;

  // One extra bit captures carry-out; a load can never carry since ACC_W >= 6.
  always_comb begin
    w_full  = '0;
    if (i_load) begin
      w_full = {{c_EXT_W{1'b0}}, i_prod};
    end else begin
      w_full = {1'b0, i_acc} + {{c_EXT_W{1'b0}}, i_prod};
    end
    o_carry = w_full[ACC_W];
`ifdef MAC3_ACC_SAT_EN
    // Once clamped, any further non-zero add carries again and stays clamped.
    o_sum = o_carry ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
    o_sum = w_full[ACC_W-1:0];
`endif
  end

endmodule
`default_nettype wire

// File: rtl/mac3_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : mac3_accumulator
// Purpose  : Sums LEN unsigned 3x3 products into one ACC_W-bit result with a
//            valid/ready handshake on both sides and a sticky overflow flag.
//            Optional macro MAC3_ACC_SAT_EN: saturate instead of wrap.
// Revision : 1.0 - initial release
// ============================================================================
module mac3_accumulator
  import mac3_pkg::*;
#(
  parameter int ACC_W = 10,
  parameter int LEN   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  mac3_accumulator_if.slave   bus
);

  // Counter must be able to hold LEN itself while a result is presented.
  localparam int c_CNT_W = (LEN > 1) ? $clog2(LEN + 1) : 1;

  mac3_state_t          r_state;
  logic [ACC_W-1:0]     r_acc;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_out_valid;
  logic                 r_ovf;
  logic                 r_in_ready;

  logic                 w_beat;
  logic                 w_load;
  logic                 w_last;
  logic [ACC_W-1:0]     w_sum;
  logic                 w_carry;

  assign w_beat = bus.in_valid & r_in_ready;
  assign w_load = (r_cnt == '0);
  assign w_last = (r_cnt == c_CNT_W'(LEN - 1));

  mac3_acc_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .i_acc   (r_acc),
    .i_prod  (bus.prod),
    .i_load  (w_load),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // Control FSM and datapath registers; clr outranks beats and handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
    end else if (clr) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          r_in_ready <= 1'b1;
          if (w_beat) begin
            r_acc <= w_sum;
            r_ovf <= w_load ? w_carry : (r_ovf | w_carry);
            r_cnt <= r_cnt + c_CNT_W'(1);
            if (w_last) begin
              r_state     <= HOLD;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_out_valid <= 1'b0;
          r_ovf       <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Result fields read as zero whenever no result is being presented.
  assign bus.out_valid = r_out_valid;
  assign bus.in_ready  = r_in_ready;
  assign bus.out_sum   = r_out_valid ? r_acc : '0;
  assign bus.out_ovf   = r_out_valid & r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mac3_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac3_accumulator
// Purpose  : Self-checking bench for mac3_accumulator. Three instances share
//            one input stream: (ACC_W=10,LEN=4), (ACC_W=7,LEN=4),
//            (ACC_W=10,LEN=1). Honours macro MAC3_ACC_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac3_accumulator;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr   = 1'b0;
  logic       iv    = 1'b0;
  logic [5:0] pd    = 6'd0;
  logic       ordy  = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mac3_accumulator_if #(.ACC_W(10)) if0 ();
  mac3_accumulator_if #(.ACC_W(7))  if1 ();
  mac3_accumulator_if #(.ACC_W(10)) if2 ();

  assign if0.in_valid = iv;  assign if0.prod = pd;  assign if0.out_ready = ordy;
  assign if1.in_valid = iv;  assign if1.prod = pd;  assign if1.out_ready = ordy;
  assign if2.in_valid = iv;  assign if2.prod = pd;  assign if2.out_ready = ordy;

  mac3_accumulator #(.ACC_W(10), .LEN(4)) u_dut0 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if0));
  mac3_accumulator #(.ACC_W(7),  .LEN(4)) u_dut1 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if1));
  mac3_accumulator #(.ACC_W(10), .LEN(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if2));

  logic       d_vld [3];
  logic       d_rdy [3];
  logic       d_ovf [3];
  logic [9:0] d_sum [3];

  assign d_vld[0] = if0.out_valid; assign d_rdy[0] = if0.in_ready;
  assign d_ovf[0] = if0.out_ovf;   assign d_sum[0] = if0.out_sum;
  assign d_vld[1] = if1.out_valid; assign d_rdy[1] = if1.in_ready;
  assign d_ovf[1] = if1.out_ovf;   assign d_sum[1] = {3'b000, if1.out_sum};
  assign d_vld[2] = if2.out_valid; assign d_rdy[2] = if2.in_ready;
  assign d_ovf[2] = if2.out_ovf;   assign d_sum[2] = if2.out_sum;

  function automatic int width_of(input int k);
    return (k == 1) ? 7 : 10;
  endfunction

  function automatic int len_of(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  // Presented value of a result whose exact (unbounded) sum is s.
  function automatic int shown_sum(input int s, input int w);
    int mx;
    mx = (1 << w) - 1;
`ifdef MAC3_ACC_SAT_EN
    return (s > mx) ? mx : s;
`else
    return s % (1 << w);
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Behavioural model: exact running sum and beat count per instance.
  int m_sum  [3] = '{0, 0, 0};
  int m_cnt  [3] = '{0, 0, 0};
  bit m_hold [3] = '{0, 0, 0};
  bit m_rdy  [3] = '{0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_sum[k] = 0; m_cnt[k] = 0; m_hold[k] = 0; m_rdy[k] = 0;
      end else if (clr) begin
        m_sum[k] = 0; m_cnt[k] = 0; m_hold[k] = 0; m_rdy[k] = 1;
      end else if (m_hold[k]) begin
        if (ordy) begin
          m_sum[k] = 0; m_cnt[k] = 0; m_hold[k] = 0;
        end
        m_rdy[k] = 1;
      end else begin
        if (iv && m_rdy[k]) begin
          m_sum[k] = (m_cnt[k] == 0) ? int'(pd) : m_sum[k] + int'(pd);
          m_cnt[k] = m_cnt[k] + 1;
          if (m_cnt[k] == len_of(k)) m_hold[k] = 1;
        end
        m_rdy[k] = 1;
      end
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("cmp_valid[%0d]", k), 32'(d_vld[k]), 32'(m_hold[k]));
      chk($sformatf("cmp_ready[%0d]", k), 32'(d_rdy[k]), 32'(m_rdy[k] & ~m_hold[k]));
      chk($sformatf("cmp_sum[%0d]", k), 32'(d_sum[k]),
          m_hold[k] ? 32'(shown_sum(m_sum[k], width_of(k))) : 32'd0);
      chk($sformatf("cmp_ovf[%0d]", k), 32'(d_ovf[k]),
          32'(m_hold[k] && (m_sum[k] > (1 << width_of(k)) - 1)));
    end
  end

  task automatic drive(input logic v, input logic [5:0] p, input logic r);
    iv = v; pd = p; ordy = r;
    @(posedge clk); #1;
  endtask

`ifdef MAC3_ACC_SAT_EN
  localparam int c_OVF_SUM = 127;
`else
  localparam int c_OVF_SUM = 19;
`endif

  initial begin
    // Reset state before any edge
    #1;
    chk("rst_valid", 32'(if0.out_valid), 32'd0);
    chk("rst_ready", 32'(if0.in_ready), 32'd0);
    chk("rst_sum",   32'(if0.out_sum), 32'd0);
    chk("rst_ovf",   32'(if0.out_ovf), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("ready_before_edge", 32'(if0.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("ready_after_edge", 32'(if0.in_ready), 32'd1);

    // Back-to-back beats, consumer always ready
    drive(1, 6'd42, 1); drive(1, 6'd49, 1); drive(1, 6'd1, 1); drive(1, 6'd0, 1);
    chk("s1_valid", 32'(if0.out_valid), 32'd1);
    chk("s1_sum",   32'(if0.out_sum), 32'd92);
    chk("s1_ovf",   32'(if0.out_ovf), 32'd0);
    drive(0, 6'd0, 1);
    chk("s1_idle_valid", 32'(if0.out_valid), 32'd0);
    chk("s1_idle_ready", 32'(if0.in_ready), 32'd1);

    // Stalled consumer: result held, inputs ignored
    drive(1, 6'd42, 0); drive(1, 6'd49, 0); drive(1, 6'd1, 0); drive(1, 6'd0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("s2_hold_sum",   32'(if0.out_sum), 32'd92);
      chk("s2_hold_ready", 32'(if0.in_ready), 32'd0);
      chk("s2_hold_valid", 32'(if0.out_valid), 32'd1);
      drive(1, 6'd49, 0);
    end
    drive(0, 6'd0, 1);
    chk("s2_release_valid", 32'(if0.out_valid), 32'd0);
    chk("s2_release_ready", 32'(if0.in_ready), 32'd1);

    // Overflow on the 7-bit instance
    drive(1, 6'd49, 1); drive(1, 6'd49, 1); drive(1, 6'd49, 1); drive(1, 6'd0, 1);
    chk("s3_ovf", 32'(if1.out_ovf), 32'd1);
    chk("s3_sum", 32'(if1.out_sum), 32'(c_OVF_SUM));
    chk("s3_wide_sum", 32'(if0.out_sum), 32'd147);
    chk("s3_wide_ovf", 32'(if0.out_ovf), 32'd0);
    drive(0, 6'd0, 1);

    // Clear coincident with a beat
    drive(1, 6'd10, 1); drive(1, 6'd20, 1);
    clr = 1'b1;
    drive(1, 6'd30, 1);
    clr = 1'b0;
    chk("s4_clr_valid", 32'(if0.out_valid), 32'd0);
    drive(1, 6'd1, 1); drive(1, 6'd2, 1); drive(1, 6'd3, 1); drive(1, 6'd4, 1);
    chk("s4_sum",   32'(if0.out_sum), 32'd10);
    chk("s4_valid", 32'(if0.out_valid), 32'd1);
    drive(0, 6'd0, 1);

    // LEN=1 instance produces one result per beat
    drive(1, 6'd7, 1);
    chk("s5_first_sum", 32'(if2.out_sum), 32'd7);
    drive(0, 6'd0, 1);
    chk("s5_gap_valid", 32'(if2.out_valid), 32'd0);
    drive(1, 6'd9, 1);
    chk("s5_second_sum", 32'(if2.out_sum), 32'd9);
    drive(0, 6'd0, 1);

    // Asynchronous reset mid-accumulation
    drive(1, 6'd5, 1);
    iv = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_valid0", 32'(if0.out_valid), 32'd0);
    chk("s6_rst_ready0", 32'(if0.in_ready), 32'd0);
    chk("s6_rst_valid2", 32'(if2.out_valid), 32'd0);
    chk("s6_rst_sum2",   32'(if2.out_sum), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("s6_ready_back", 32'(if0.in_ready), 32'd1);
    drive(1, 6'd1, 1); drive(1, 6'd2, 1); drive(1, 6'd3, 1); drive(1, 6'd4, 1);
    chk("s6_fresh_sum", 32'(if0.out_sum), 32'd10);
    drive(0, 6'd0, 1);
    repeat (2) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
